// File: rtl/bank_write_router.sv
// bank_write_router: merges AU results, a range-fill engine and a buffered
// external write queue onto the single Data Bank write port.
// The three sources are served in fixed priority: AU first, then fill, then queue.
// Ports:
//   clk, rst_n             clock and async active-low reset
//   DATA_IN, DIR,
//   ext_valid / ext_ready  external write queue input; DIR also feeds dirb
//   result, ctl_a,
//   res_valid              AU write; it is never stalled
//   ctl_b, sel_dirb        read address select; dirb is combinational
//   fill_start, fill_ones,
//   fill_lo, fill_hi       range-fill request
//   fill_busy              the fill engine is active
//   ext_level              queue occupancy
//   READY                  no fill, queue empty and no write in flight
//   data, dira, write      registered Data Bank write port
module bank_write_router #(
  parameter int unsigned W     = 24,
  parameter int unsigned ADDRW = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [W-1:0]               DATA_IN,
  input  logic [ADDRW-1:0]           DIR,
  input  logic                       ext_valid,
  output logic                       ext_ready,
  input  logic [W-1:0]               result,
  input  logic [ADDRW-1:0]           ctl_a,
  input  logic                       res_valid,
  input  logic [ADDRW-1:0]           ctl_b,
  input  logic                       sel_dirb,
  input  logic                       fill_start,
  input  logic                       fill_ones,
  input  logic [ADDRW-1:0]           fill_lo,
  input  logic [ADDRW-1:0]           fill_hi,
  output logic                       fill_busy,
  output logic [$clog2(DEPTH):0]     ext_level,
  output logic                       READY,
  output logic [W-1:0]               data,
  output logic [ADDRW-1:0]           dira,
  output logic [ADDRW-1:0]           dirb,
  output logic                       write
);

  localparam int unsigned PTRW = $clog2(DEPTH);
  localparam int unsigned LVLW = PTRW + 1;

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [ADDRW-1:0] cnt_q, cnt_d;
  logic [ADDRW-1:0] hi_q, hi_d;
  logic             ones_q, ones_d;
  logic [PTRW-1:0]  wptr_q, wptr_d;
  logic [PTRW-1:0]  rptr_q, rptr_d;
  logic [LVLW-1:0]  level_q, level_d;
  logic [W-1:0]     mem_data_q [DEPTH];
  logic [W-1:0]     mem_data_d [DEPTH];
  logic [ADDRW-1:0] mem_dir_q  [DEPTH];
  logic [ADDRW-1:0] mem_dir_d  [DEPTH];
  logic             write_q, write_d;
  logic [W-1:0]     data_q, data_d;
  logic [ADDRW-1:0] dira_q, dira_d;
  logic             push, pop;

  // Arbitration, the fill FSM and the queue bookkeeping
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    ones_d     = ones_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    mem_data_d = mem_data_q;
    mem_dir_d  = mem_dir_q;
    write_d    = 1'b0;
    data_d     = data_q;
    dira_d     = dira_q;
    pop        = 1'b0;
    // A full queue refuses the push even if it pops in the same cycle
    push       = ext_valid && (level_q != LVLW'(DEPTH));

    if (res_valid) begin
      write_d = 1'b1;
      data_d  = result;
      dira_d  = ctl_a;
    end else if (state_q == FILL) begin
      write_d = 1'b1;
      data_d  = {W{ones_q}};
      dira_d  = cnt_q;
    end else if (level_q != '0) begin
      pop     = 1'b1;
      write_d = 1'b1;
      data_d  = mem_data_q[rptr_q];
      dira_d  = mem_dir_q[rptr_q];
    end

    case (state_q)
      IDLE: begin
        if (fill_start && (fill_lo <= fill_hi)) begin
          state_d = FILL;
          cnt_d   = fill_lo;
          hi_d    = fill_hi;
          ones_d  = fill_ones;
        end
      end
      FILL: begin
        // The fill ends by comparing against hi, so the counter never wraps
        if (!res_valid) begin
          if (cnt_q == hi_q) state_d = IDLE;
          else               cnt_d   = cnt_q + ADDRW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      mem_data_d[wptr_q] = DATA_IN;
      mem_dir_d[wptr_q]  = DIR;
      wptr_d             = wptr_q + PTRW'(1);
    end
    if (pop) rptr_d = rptr_q + PTRW'(1);
    level_d = level_q + LVLW'(push) - LVLW'(pop);
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      ones_q  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      write_q <= 1'b0;
      data_q  <= '0;
      dira_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_data_q[i] <= '0;
        mem_dir_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      ones_q     <= ones_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      write_q    <= write_d;
      data_q     <= data_d;
      dira_q     <= dira_d;
      mem_data_q <= mem_data_d;
      mem_dir_q  <= mem_dir_d;
    end
  end

  assign write     = write_q;
  assign data      = data_q;
  assign dira      = dira_q;
  assign fill_busy = (state_q == FILL);
  assign ext_level = level_q;
  assign ext_ready = (level_q != LVLW'(DEPTH));
  assign READY     = (state_q == IDLE) && (level_q == '0) && !write_q;
  assign dirb      = sel_dirb ? DIR : ctl_b;

endmodule

// File: tb/tb_bank_write_router.sv
// Directed testbench for bank_write_router. The expected values are computed by hand.
module tb_bank_write_router;
  localparam int unsigned W = 24, ADDRW = 5, DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [W-1:0]     DATA_IN, result, data;
  logic [ADDRW-1:0] DIR, ctl_a, ctl_b, fill_lo, fill_hi, dira, dirb;
  logic             ext_valid, ext_ready, res_valid, sel_dirb;
  logic             fill_start, fill_ones, fill_busy, READY, write;
  logic [2:0]       ext_level;

  int checks = 0;
  int errors = 0;
  int idx;
  logic acc;

  bank_write_router #(.W(W), .ADDRW(ADDRW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .DATA_IN(DATA_IN), .DIR(DIR),
    .ext_valid(ext_valid), .ext_ready(ext_ready), .result(result),
    .ctl_a(ctl_a), .res_valid(res_valid), .ctl_b(ctl_b), .sel_dirb(sel_dirb),
    .fill_start(fill_start), .fill_ones(fill_ones), .fill_lo(fill_lo),
    .fill_hi(fill_hi), .fill_busy(fill_busy), .ext_level(ext_level),
    .READY(READY), .data(data), .dira(dira), .dirb(dirb), .write(write)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_wr(input string tag, input logic [31:0] d, input logic [31:0] a);
    step();
    check_eq({tag, "_we"},   32'(write), 32'd1);
    check_eq({tag, "_data"}, 32'(data),  d);
    check_eq({tag, "_dira"}, 32'(dira),  a);
  endtask

  task automatic exp_nowr(input string tag);
    step();
    check_eq({tag, "_we"}, 32'(write), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; DATA_IN = '0; DIR = '0; ext_valid = 1'b0; result = '0;
    ctl_a = '0; res_valid = 1'b0; ctl_b = '0; sel_dirb = 1'b0;
    fill_start = 1'b0; fill_ones = 1'b0; fill_lo = '0; fill_hi = '0;

    // Reset values
    #12;
    check_eq("rst_write", 32'(write), 0);
    check_eq("rst_data", 32'(data), 0);
    check_eq("rst_dira", 32'(dira), 0);
    check_eq("rst_busy", 32'(fill_busy), 0);
    check_eq("rst_level", 32'(ext_level), 0);
    check_eq("rst_ready", 32'(ext_ready), 1);
    check_eq("rst_READY", 32'(READY), 1);
    rst_n = 1'b1;

    // dirb select
    ctl_b = 5'd9; DIR = 5'd3; #1;
    check_eq("dirb_ctlb", 32'(dirb), 9);
    sel_dirb = 1'b1; #1;
    check_eq("dirb_dir", 32'(dirb), 3);
    sel_dirb = 1'b0;

    // Three back-to-back pushes drain in order
    ext_valid = 1'b1; DATA_IN = 24'h000011; DIR = 5'd3;
    step();
    check_eq("q1_nowr", 32'(write), 0);
    check_eq("q1_level", 32'(ext_level), 1);
    DATA_IN = 24'h000022; DIR = 5'd7;
    exp_wr("q1_w0", 32'h11, 3);
    DATA_IN = 24'h000033; DIR = 5'd1;
    exp_wr("q1_w1", 32'h22, 7);
    ext_valid = 1'b0;
    exp_wr("q1_w2", 32'h33, 1);
    check_eq("q1_READY_busy", 32'(READY), 0);
    exp_nowr("q1_idle");
    check_eq("q1_hold_data", 32'(data), 32'h33);
    check_eq("q1_hold_dira", 32'(dira), 1);
    check_eq("q1_READY", 32'(READY), 1);

    // Fill the queue while the AU holds the port, then drain it
    res_valid = 1'b1; result = 24'hAAAAAA; ctl_a = 5'd2; ext_valid = 1'b1;
    idx = 0;
    for (int c = 0; c < DEPTH + 2; c++) begin
      DATA_IN = W'(32'h100 + idx); DIR = ADDRW'(10 + idx);
      acc = ext_ready;
      step();
      if (acc) idx++;
      check_eq("full_au_data", 32'(data), 32'hAAAAAA);
      check_eq("full_au_dira", 32'(dira), 2);
    end
    check_eq("full_pushed", 32'(idx), DEPTH);
    check_eq("full_level", 32'(ext_level), DEPTH);
    check_eq("full_ready", 32'(ext_ready), 0);
    ext_valid = 1'b0;
    step();
    check_eq("full_level_hold", 32'(ext_level), DEPTH);
    res_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_wr("drain", 32'h100 + i, 10 + i);
      if (i == 0) begin
        check_eq("drain_ready", 32'(ext_ready), 1);
        check_eq("drain_level", 32'(ext_level), DEPTH - 1);
      end
    end
    exp_nowr("drain_end");

    // Uninterrupted fill of 4..9 with ones
    fill_start = 1'b1; fill_lo = 5'd4; fill_hi = 5'd9; fill_ones = 1'b1;
    step();
    fill_start = 1'b0;
    check_eq("f1_busy", 32'(fill_busy), 1);
    check_eq("f1_nowr", 32'(write), 0);
    for (int i = 0; i < 6; i++) begin
      exp_wr("f1", 32'hFFFFFF, 4 + i);
      check_eq("f1_busy_run", 32'(fill_busy), (i == 5) ? 0 : 1);
    end
    exp_nowr("f1_end");

    // A fill interrupted by an AU write resumes at the pending address
    fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    exp_wr("f2", 32'hFFFFFF, 4);
    exp_wr("f2", 32'hFFFFFF, 5);
    res_valid = 1'b1; result = 24'h123456; ctl_a = 5'd20;
    exp_wr("f2_au", 32'h123456, 20);
    check_eq("f2_busy_au", 32'(fill_busy), 1);
    res_valid = 1'b0;
    for (int i = 6; i < 10; i++) exp_wr("f2", 32'hFFFFFF, i);
    check_eq("f2_busy_end", 32'(fill_busy), 0);
    exp_nowr("f2_end");

    // The top of the address space terminates without wrapping
    fill_start = 1'b1; fill_lo = 5'd28; fill_hi = 5'd31; fill_ones = 1'b0;
    step();
    fill_start = 1'b0;
    for (int i = 28; i < 32; i++) exp_wr("f3", 0, i);
    check_eq("f3_busy_end", 32'(fill_busy), 0);
    exp_nowr("f3_nowrap");

    // A range with lo > hi is ignored
    fill_start = 1'b1; fill_lo = 5'd5; fill_hi = 5'd2; fill_ones = 1'b1;
    exp_nowr("f4_ign");
    fill_start = 1'b0;
    check_eq("f4_busy", 32'(fill_busy), 0);
    exp_nowr("f4_ign2");

    // Queued entries wait behind a fill, and a second start during FILL is ignored
    res_valid = 1'b1; result = 24'h555555; ctl_a = 5'd30;
    ext_valid = 1'b1; DATA_IN = 24'h0000A1; DIR = 5'd11;
    step();
    DATA_IN = 24'h0000B2; DIR = 5'd12;
    step();
    ext_valid = 1'b0;
    fill_start = 1'b1; fill_lo = 5'd0; fill_hi = 5'd1; fill_ones = 1'b1;
    exp_wr("f5_au", 32'h555555, 30);
    check_eq("f5_level", 32'(ext_level), 2);
    check_eq("f5_busy", 32'(fill_busy), 1);
    res_valid = 1'b0; fill_lo = 5'd20; fill_hi = 5'd21; fill_ones = 1'b0;
    exp_wr("f5_fill", 32'hFFFFFF, 0);
    fill_start = 1'b0;
    exp_wr("f5_fill", 32'hFFFFFF, 1);
    exp_wr("f5_q", 32'hA1, 11);
    exp_wr("f5_q", 32'hB2, 12);
    exp_nowr("f5_end");
    check_eq("f5_busy_end", 32'(fill_busy), 0);
    check_eq("f5_READY", 32'(READY), 1);

    // Reset in the middle of a fill with a non-empty queue
    res_valid = 1'b1; result = 24'h0F0F0F; ctl_a = 5'd1;
    ext_valid = 1'b1; DATA_IN = 24'h0000C3; DIR = 5'd9;
    step();
    ext_valid = 1'b0;
    fill_start = 1'b1; fill_lo = 5'd10; fill_hi = 5'd15; fill_ones = 1'b0;
    step();
    fill_start = 1'b0; res_valid = 1'b0;
    exp_wr("f6_fill", 0, 10);
    rst_n = 1'b0;
    #1;
    check_eq("f6_rst_we", 32'(write), 0);
    check_eq("f6_rst_busy", 32'(fill_busy), 0);
    check_eq("f6_rst_level", 32'(ext_level), 0);
    check_eq("f6_rst_dira", 32'(dira), 0);
    sel_dirb = 1'b1; DIR = 5'd9; ctl_b = 5'd17; #1;
    check_eq("f6_dirb_dir", 32'(dirb), 9);
    sel_dirb = 1'b0; #1;
    check_eq("f6_dirb_ctlb", 32'(dirb), 17);
    exp_nowr("f6_in_rst");
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) exp_nowr("f6_after");
    check_eq("f6_level", 32'(ext_level), 0);
    check_eq("f6_busy", 32'(fill_busy), 0);
    check_eq("f6_READY", 32'(READY), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bank_write_router.md
# bank_write_router

Parametrised, clocked write-side router for the Data Bank. It merges three write sources onto the single Data Bank write port under fixed priority: AU results (never stalled), a range-fill engine (constant 0 or all-ones), and a DEPTH-entry buffered external write queue. It drives registered `data`, `dira` and `write`, and exposes `READY` and queue status to the external interface and the sequencer; the read address `dirb` is muxed here as well.

## Interface
- `W`, 24, data width
- `ADDRW`, 5, Data Bank address width
- `DEPTH`, 4, external write queue depth; power of two, >= 2
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `DATA_IN`  in  W  external write data
- `DIR`  in  ADDRW  external address; also the read address when `sel_dirb`=1
- `ext_valid`  in  1  external write request
- `ext_ready`  out  1  queue can accept; equals queue not full
- `result`  in  W  AU result
- `ctl_a`  in  ADDRW  sequencer write address for `result`
- `res_valid`  in  1  AU result write, one per cycle, never back-pressured
- `ctl_b`  in  ADDRW  sequencer read address
- `sel_dirb`  in  1  0 = `ctl_b`, 1 = `DIR`
- `fill_start`  in  1  start range fill (single-cycle pulse)
- `fill_ones`  in  1  fill value: 0 = all zeros, 1 = all ones
- `fill_lo`, `fill_hi`  in  ADDRW each  inclusive fill address range
- `fill_busy`  out  1  fill engine active
- `ext_level`  out  $clog2(DEPTH)+1  queue occupancy
- `READY`  out  1  no fill active, queue empty, no write in flight
- `data`  out  W  write data to Data Bank, registered
- `dira`  out  ADDRW  port A address, registered
- `dirb`  out  ADDRW  port B address, combinational
- `write`  out  1  write enable, registered, one write per cycle

## Operation
- Queue: circular FIFO of {DATA_IN, DIR}. Push when `ext_valid && ext_ready`. Full means no push, with no same-cycle pop pass-through. Pointers wrap modulo DEPTH; `ext_level` counts 0..DEPTH.
- Fill FSM has two states, IDLE and FILL.
  - IDLE -> FILL on `fill_start` when `fill_lo <= fill_hi`. The start cycle latches lo, hi and value, and the counter loads lo.
  - `fill_start` with lo > hi is ignored. `fill_start` while in FILL is ignored.
  - In FILL, each granted cycle writes the constant to the counter address. After the write at address hi, return to IDLE.
  - The hi == 2^ADDRW-1 case must terminate by comparison, not by counter overflow.
- Arbitration each cycle, highest priority first:
  1. `res_valid` writes `result` to `ctl_a`.
  2. FILL writes the fill word to the counter address.
  3. Queue not empty: pop the head.
  4. No source: `write`=0, and `data`/`dira` hold their previous values.
- A fill or a queue entry loses its slot only to a higher source. It waits and is never dropped. Queue entries write in push order.
- `dirb` = `sel_dirb ? DIR : ctl_b`.
- `READY` = IDLE, queue empty, and `write`=0.

## Timing
- Reset (async assert, sync release): `data`=0, `dira`=0, `write`=0, `fill_busy`=0, queue empty, `ext_level`=0, `ext_ready`=1, `READY`=1, FSM in IDLE.
- AU latency: `res_valid` at edge k gives `write`=1 with `result`/`ctl_a` visible after edge k.
- Queue latency: an entry pushed at edge k is written no earlier than edge k+1. It is delayed one cycle per higher-priority grant.
- Fill: `fill_start` at edge k sets `fill_busy`=1 after edge k. The first write (address lo) appears after edge k+1. An uninterrupted fill of N addresses writes on N consecutive cycles. `fill_busy` falls on the same edge as the last write.
- `ext_ready` and `ext_level` reflect state after the current edge. A pop at a full queue raises `ext_ready` on the next cycle.
- Reset asserted mid-fill or mid-drain aborts the operation and discards queue contents. No further writes occur after reset.

## Test plan
- Reset, then push (0x000011, 3), (0x000022, 7), (0x000033, 1) back-to-back -> writes occur in that order on 3 consecutive cycles starting one cycle after the first push; `READY` returns to 1 afterwards.
- Push DEPTH+2 entries with `ext_valid` held high and no drain (`res_valid`=1 continuously) -> `ext_ready`=0 at `ext_level`=DEPTH, no entry lost or duplicated. Release `res_valid` -> all DEPTH entries drain in order.
- Fill lo=4, hi=9, ones -> 0xFFFFFF written to addresses 4..9 on 6 consecutive cycles. With `res_valid` pulsed at the third fill cycle -> the AU write is inserted and the fill resumes at the pending address, still ending at 9.
- Fill lo=28, hi=31 (ADDRW=5), zeros -> writes to 28..31, then `fill_busy`=0 with no wrap to address 0. Fill lo=5, hi=2 -> ignored, no writes, `fill_busy` stays 0.
- Queue holding 2 entries while a fill starts -> fill writes complete first, then the queue drains. `fill_start` during FILL -> ignored.
- Assert `rst_n`=0 mid-fill with a non-empty queue -> `write`, `fill_busy` and `ext_level` go to 0 immediately; after release, no residual writes; `dirb` follows `sel_dirb` throughout.
